// File: rtl/se_acc.sv
// se_acc: per-entry signed partial-sum accumulator with forwarding,
// self-clearing buffer and valid/ready output. Optional macro: SE_SAT_EN.
// Ports: clk, rst_n | in_valid/in_ready/in_op/in_addr/in_data (beat in)
//        out_valid/out_ready/out_addr/out_data (sum out) | busy, ovf.
module se_acc #(
  parameter int DW    = 16,
  parameter int SW    = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [SW-1:0] out_data,
  output logic          busy,
  output logic          ovf
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_ACC   = 2'b10;
  localparam logic [1:0] OP_DRAIN = 2'b11;

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;

  logic [SW-1:0] mem_q [DEPTH];

  logic          s1_v_q;
  logic [1:0]    s1_op_q;
  logic [AW-1:0] s1_addr_q;
  logic [SW-1:0] s1_data_q;
  logic [SW-1:0] s1_opnd_q;

  logic          out_valid_q;
  logic [AW-1:0] out_addr_q;
  logic [SW-1:0] out_data_q;
  logic          ovf_q;

  logic                 adv;
  logic                 exe;
  logic signed [DW-1:0] in_s;
  logic [SW-1:0]        in_sx;
  logic [SW-1:0]        res;
  logic                 clamp;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [SW-1:0]        wr_data;
  logic                 is_drain;
  logic                 sat_hit;
  logic [SW-1:0]        opnd_d;

  // Whole pipeline advances only when the output slot is free.
  assign adv      = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign exe      = adv && s1_v_q;
  assign in_ready = adv;
  assign busy     = (state_q == S_CLEAR);

  assign in_s  = in_data;
  assign in_sx = SW'(in_s);

`ifdef SE_SAT_EN
  logic [SW:0] sum_w;
  assign sum_w = {s1_opnd_q[SW-1], s1_opnd_q}
               + {s1_data_q[SW-1], s1_data_q};
  // Top two bits disagree: result left the SW-bit range.
  assign clamp = sum_w[SW] ^ sum_w[SW-1];
  always_comb begin
    res = sum_w[SW-1:0];
    if (clamp) begin
      res = sum_w[SW] ? {1'b1, {(SW-1){1'b0}}}
                      : {1'b0, {(SW-1){1'b1}}};
    end
  end
`else
  assign res   = s1_opnd_q + s1_data_q;
  assign clamp = 1'b0;
`endif

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = s1_addr_q;
    wr_data  = '0;
    is_drain = 1'b0;
    sat_hit  = 1'b0;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
    end else if (exe) begin
      unique case (s1_op_q)
        OP_LOAD: begin
          wr_en   = 1'b1;
          wr_data = s1_data_q;
        end
        OP_ACC: begin
          wr_en   = 1'b1;
          wr_data = res;
          sat_hit = clamp;
        end
        OP_DRAIN: begin
          wr_en    = 1'b1;
          is_drain = 1'b1;
          sat_hit  = clamp;
        end
        default: ;
      endcase
    end
  end

  // Operand captured at accept sees the write retiring on the same edge.
  assign opnd_d = (wr_en && wr_addr == in_addr) ? wr_data
                                                : mem_q[in_addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_op_q     <= '0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      s1_opnd_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(DEPTH - 1)) state_q <= S_RUN;
        end
        default: ;
      endcase
      if (adv) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_op_q   <= in_op;
          s1_addr_q <= in_addr;
          s1_data_q <= in_sx;
          s1_opnd_q <= opnd_d;
        end
      end
      if (is_drain) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= s1_addr_q;
        out_data_q  <= res;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (sat_hit) ovf_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
`ifdef SE_SAT_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_se_acc.sv
// tb_se_acc: randomized + directed bench for se_acc with an in-bench
// reference model (per-entry array and ordered result queue).
module tb_se_acc;
  localparam int DW = 16;
  localparam int SW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_addr, out_addr;
  logic [DW-1:0] in_data;
  logic [SW-1:0] out_data;
  logic          busy, ovf;

  se_acc #(.DW(DW), .SW(SW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .ovf(ovf)
  );

  logic        v2, r2, ov2, ordy2, busy2, ovf2;
  logic [1:0]  op2, a2, oa2;
  logic [15:0] d2, od2;

  se_acc #(.DW(16), .SW(16), .DEPTH(4)) u_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(r2),
    .in_op(op2), .in_addr(a2), .in_data(d2),
    .out_valid(ov2), .out_ready(ordy2),
    .out_addr(oa2), .out_data(od2),
    .busy(busy2), .ovf(ovf2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // ---------------- reference model ----------------
  longint mb [DEPTH];
  int     qa [$];
  longint qd [$];
  bit     pv;
  logic [1:0]    pop_;
  int            pa;
  logic [DW-1:0] pd;
  int     edges = 0;
  bit     movf = 0;
  bit     rdy;

  function automatic longint sx(input logic [DW-1:0] d);
    return longint'($signed(d));
  endfunction

  function automatic longint fix(input longint v);
    longint m, hi, lo, r;
    m  = longint'(1) << SW;
    hi = m / 2 - 1;
    lo = -(m / 2);
    r  = v;
`ifdef SE_SAT_EN
    if (v > hi) begin movf = 1; r = hi; end
    if (v < lo) begin movf = 1; r = lo; end
`else
    r = v & (m - 1);
    if (r > hi) r = r - m;
`endif
    return r;
  endfunction

  task automatic retire();
    case (pop_)
      2'b01: mb[pa] = sx(pd);
      2'b10: mb[pa] = fix(mb[pa] + sx(pd));
      2'b11: begin
        qa.push_back(pa);
        qd.push_back(fix(mb[pa] + sx(pd)));
        mb[pa] = 0;
      end
      default: ;
    endcase
  endtask

  always @(negedge rst_n) begin
    foreach (mb[i]) mb[i] = 0;
    qa.delete();
    qd.delete();
    pv = 0;
    edges = 0;
    movf = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      rdy = (edges >= DEPTH) && (qa.size() == 0 || out_ready);
      if (qa.size() != 0 && out_ready) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (rdy) begin
        if (pv) retire();
        pv   = in_valid;
        pop_ = in_op;
        pa   = int'(in_addr);
        pd   = in_data;
      end
      if (edges < DEPTH) edges++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [SW-1:0] e;
    #1;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_ovf", ovf, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
    end else begin
      chk("busy", busy, edges < DEPTH);
      chk("in_ready", in_ready,
          (edges >= DEPTH) && (qa.size() == 0 || out_ready));
      chk("out_valid", out_valid, qa.size() != 0);
      chk("ovf", ovf, movf);
      if (qa.size() != 0) begin
        e = SW'(qd[0]);
        chk("out_data", out_data, e);
        chk("out_addr", out_addr, qa[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_or = 0;
  always @(negedge clk) begin
    if (rnd_or) out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic send(input logic [1:0] op, input int a,
                      input logic [DW-1:0] d);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = AW'(a);
    in_data  = d;
    #1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 200) timeout("send");
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
  endtask

  task automatic expect_out(input string nm, input int a,
                            input logic [SW-1:0] d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) timeout(nm);
    else begin
      chk({nm, "_lat"}, n, 2);
      chk({nm, "_data"}, out_data, d);
      chk({nm, "_addr"}, out_addr, a);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [1:0]  o2s [3];
    logic [15:0] d2s [3];
    o2s = '{2'b01, 2'b10, 2'b11};
    d2s = '{16'h7FFF, 16'h0001, 16'h0000};
    in_valid = 0; in_op = 0; in_addr = 0; in_data = 0;
    out_ready = 1;
    v2 = 0; op2 = 0; a2 = 0; d2 = 0; ordy2 = 1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    #1;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("busy_cycles", cnt, 16);
    chk("in_ready_rise", in_ready, 1);
    chk("out_data_init", out_data, 0);

    // Narrow instance: SW == DW == 16, overflow behaviour.
    for (int i = 0; i < 3; i++) begin
      int g;
      @(negedge clk);
      v2 = 1; op2 = o2s[i]; a2 = 2'd1; d2 = d2s[i];
      #1;
      g = 0;
      while (!r2 && g < 50) begin
        @(negedge clk);
        #1;
        g++;
      end
      if (g >= 50) timeout("n_send");
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    v2 = 0;
    cnt = 0;
    #1;
    while (!ov2 && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
`ifdef SE_SAT_EN
    chk("n_sat_data", od2, 16'h7FFF);
    chk("n_sat_ovf", ovf2, 1);
`else
    chk("n_wrap_data", od2, 16'h8000);
    chk("n_wrap_ovf", ovf2, 0);
`endif
    chk("n_addr", oa2, 1);

    // Accumulate sequence and self-clear on drain.
    send(2'b10, 3, 16'd5);
    send(2'b10, 3, 16'hFFFE);
    send(2'b10, 3, 16'd7);
    send(2'b11, 3, 16'd0);
    expect_out("acc_seq", 3, 32'd10);
    send(2'b11, 3, 16'd0);
    expect_out("acc_redrain", 3, 32'd0);

    // Sign extension plus forwarding.
    send(2'b01, 0, 16'h8000);
    send(2'b11, 0, 16'd1);
    expect_out("load_sx", 0, 32'hFFFF8001);

    // Backpressure.
    send(2'b01, 5, 16'd100);
    send(2'b01, 6, 16'hFFFD);
    out_ready = 1'b0;
    send(2'b11, 5, 16'd1);
    send(2'b11, 6, 16'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 32'd101);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", out_data, 32'hFFFFFFFD);
    chk("bp_second_addr", out_addr, 6);
    @(negedge clk);
    out_ready = 1'b1;
    idle();

    // Reset with a beat in S1 and a result pending.
    send(2'b01, 9, 16'd4);
    out_ready = 1'b0;
    send(2'b11, 2, 16'd0);
    send(2'b10, 9, 16'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    #1;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("reclear_cycles", cnt, 16);
    send(2'b11, 9, 16'd0);
    expect_out("post_rst", 9, 32'd0);

    // Randomized traffic against the model.
    rnd_or = 1;
    for (int i = 0; i < 1500; i++) begin
      int a;
      if ($urandom_range(0, 3) == 0) idle();
      else begin
        a = $urandom_range(0, 1) ? $urandom_range(0, 3)
                                 : $urandom_range(0, DEPTH - 1);
        send(2'($urandom_range(0, 3)), a, DW'($urandom));
      end
    end
    idle();
    rnd_or = 0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("final_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
